// File: rtl/dmem_mmio_pkg.sv
// ----------------------------------------------------------------------------
// dmem_mmio_pkg
//   Shared constants for the data-memory / MMIO responder: the I/O page
//   address map, STATUS register bit layout and the read-mux select type.
// ----------------------------------------------------------------------------
package dmem_mmio_pkg;

  // I/O page register addresses (word aligned).
  localparam logic [31:0] ADDR_GPIO   = 32'h0000_1000;
  localparam logic [31:0] ADDR_TXDATA = 32'h0000_1004;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1008;
  localparam logic [31:0] ADDR_CYCLES = 32'h0000_100C;

  // STATUS register layout.
  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_OVERFLOW  = 2;
  localparam int STAT_COUNT_LSB = 8;
  localparam int COUNT_W        = 8;

  // Which target the current bus address selects.
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_GPIO,
    SEL_TXDATA,
    SEL_STATUS,
    SEL_CYCLES
  } sel_e;

endpackage

// File: rtl/tx_fifo.sv
// ----------------------------------------------------------------------------
// tx_fifo
//   Synchronous FIFO used as the MMIO transmit queue. Pushes while full are
//   dropped; pops while empty are ignored. The head word is presented from
//   registered state and reads as zero while the FIFO is empty.
//
// Ports
//   clk        in          rising-edge clock
//   rst_n      in          asynchronous active-low reset (empties the FIFO)
//   push       in          enqueue push_data this cycle (ignored when full)
//   push_data  in  WIDTH   data to enqueue
//   pop        in          dequeue the head this cycle (ignored when empty)
//   pop_data   out WIDTH   head entry, 0 when empty
//   full       out         DEPTH entries held
//   empty      out         no entries held
//   count      out CW      number of entries held (0..DEPTH)
// ----------------------------------------------------------------------------
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Acceptance uses pre-edge state only, so a pop in the same cycle never
  // makes room for a push into a full FIFO.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign pop_data = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are power-of-two wide, so they wrap modulo DEPTH naturally.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by the pointers
  // and count, and the empty mux hides stale entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio.sv
// ----------------------------------------------------------------------------
// dmem_mmio
//   Data-memory responder for a single-cycle RISC-V core. Serves a word RAM
//   at 0x0 and an I/O page at 0x1000 (GPIO, TX FIFO data, STATUS, CYCLES).
//   Reads are combinational; writes and all state update on the rising edge.
//
// Ports
//   clk        in      rising-edge clock
//   reset      in      asynchronous active-low reset
//   MemWrite   in      write strobe for the current cycle
//   ALUResult  in  32  byte address, [1:0] ignored
//   WriteData  in  32  write data
//   ReadData   out 32  read data, combinational from address and state
//   gpio_out   out 32  GPIO output register
//   tx_data    out 8   TX FIFO head byte, 0 when empty
//   tx_valid   out     TX FIFO not empty
//   tx_ready   in      consumer accepts the head byte this cycle
// ----------------------------------------------------------------------------
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(DEPTH_WORDS);
  localparam int FCW    = $clog2(FIFO_DEPTH) + 1;

  sel_e              sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram [DEPTH_WORDS];
  logic [31:0]       cycles;
  logic              overflow;
  logic [31:0]       status;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCW-1:0]    fifo_count;

  // Word access only: the byte offset takes no part in decode.
  logic [1:0] unused_byte_offset;
  assign unused_byte_offset = ALUResult[1:0];

  assign ram_idx = ALUResult[RAM_AW+1:2];

  // Address decode: every upper address bit participates, so nothing aliases.
  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    sel = SEL_NONE;
    if (ALUResult[31:RAM_AW+2] == '0)               sel = SEL_RAM;
    else if (ALUResult[31:2] == ADDR_GPIO[31:2])    sel = SEL_GPIO;
    else if (ALUResult[31:2] == ADDR_TXDATA[31:2])  sel = SEL_TXDATA;
    else if (ALUResult[31:2] == ADDR_STATUS[31:2])  sel = SEL_STATUS;
    else if (ALUResult[31:2] == ADDR_CYCLES[31:2])  sel = SEL_CYCLES;
  end

  always_ff @(posedge clk) begin
    if (MemWrite && sel == SEL_RAM) ram[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_out <= '0;
      cycles   <= '0;
      overflow <= 1'b0;
    end else begin
      cycles <= cycles + 32'd1;
      if (MemWrite && sel == SEL_GPIO) gpio_out <= WriteData;
      // Sticky until any STATUS write; a dropped push sets it.
      if (MemWrite && sel == SEL_STATUS)                  overflow <= 1'b0;
      else if (MemWrite && sel == SEL_TXDATA && fifo_full) overflow <= 1'b1;
    end
  end

  assign fifo_push = MemWrite && (sel == SEL_TXDATA);
  assign fifo_pop  = tx_valid && tx_ready;

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (fifo_push),
    .push_data (WriteData[7:0]),
    .pop       (fifo_pop),
    .pop_data  (tx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign tx_valid = !fifo_empty;

  always_comb begin
    status                                = '0;
    status[STAT_FULL]                     = fifo_full;
    status[STAT_EMPTY]                    = fifo_empty;
    status[STAT_OVERFLOW]                 = overflow;
    status[STAT_COUNT_LSB +: COUNT_W]     = COUNT_W'(fifo_count);
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible yet.
  always_comb begin
    ReadData = '0;
    case (sel)
      SEL_RAM:    ReadData = ram[ram_idx];
      SEL_GPIO:   ReadData = gpio_out;
      SEL_STATUS: ReadData = status;
      SEL_CYCLES: ReadData = cycles;
      default:    ReadData = '0;
    endcase
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory responder for the single-cycle RISC-V core: it serves the core's data-side bus (`MemWrite`, `ALUResult` as address, `WriteData`, `ReadData`) with a word RAM plus a small memory-mapped I/O page. The I/O page holds:
- a GPIO output register,
- a free-running cycle counter,
- a byte-wide transmit FIFO drained by an external consumer over a valid/ready handshake.

Reads are combinational, because the single-cycle core consumes `ReadData` in the same cycle. All writes and internal state are clocked.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: RAM size in 32-bit words; power of two, ≤ 1024.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, ≥ 2.

Ports:
- `clk` in 1: the single clock; rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `MemWrite` in 1: write strobe for the current cycle.
- `ALUResult` in 32: byte address; `[1:0]` ignored (word access only).
- `WriteData` in 32: write data.
- `ReadData` out 32: read data, combinational from address.
- `gpio_out` out 32: GPIO register.
- `tx_data` out 8: FIFO head byte; 0 when FIFO empty.
- `tx_valid` out 1: FIFO not empty.
- `tx_ready` in 1: consumer accepts head this cycle.

## Operation
Address map (full 32-bit compare):
- 0x0 to `DEPTH_WORDS*4-1`: RAM, read/write.
- 0x1000 GPIO: read/write.
- 0x1004 TXDATA:
  - Write pushes `WriteData[7:0]`.
  - Read returns 0.
- 0x1008 STATUS: bit0 full, bit1 empty, bit2 overflow, bits[15:8] count.
  - Any write clears overflow.
  - Other bits are read-only.
- 0x100C CYCLES: read-only 32-bit counter.

Write and read rules:
- Writes to unmapped or read-only locations are ignored.
- Reads of unmapped addresses return 0.

Cycle counter:
- Increments every clock after reset deasserts.
- Wraps 0xFFFFFFFF to 0.

FIFO:
- Push: a TXDATA write when not full.
  - A TXDATA write while full is dropped and sets overflow (sticky).
  - Fullness is judged on pre-edge state: a simultaneous pop does not make room for a push to a full FIFO.
- Pop: `tx_valid && tx_ready`, sampled at the clock edge.
- Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, order preserved.
- Push to an empty FIFO: the byte appears on `tx_data` with `tx_valid=1` the next cycle.
- Pointers wrap modulo `FIFO_DEPTH`.

Reset values (asynchronous, on `reset=0`):
- `gpio_out`=0, CYCLES=0, FIFO empty, overflow=0.
- `tx_valid`=0, `tx_data`=0.
- RAM contents are not reset (X until written).
- Reset asserted mid-transfer discards FIFO contents; no pop is reported.

## Timing
- `ReadData`: zero latency, combinational from `ALUResult` and current state.
- Writes commit at the rising edge while `MemWrite=1`.
  - A read of the same location in the same cycle returns the pre-edge value.
- STATUS and CYCLES reads return pre-edge values.
- `tx_data` and `tx_valid` are driven from registered FIFO state only, with no combinational path from `tx_ready`.
- Throughput: one push and one pop per cycle.

## Structure
- Package `dmem_mmio_pkg` holds:
  - address constants `ADDR_GPIO`, `ADDR_TXDATA`, `ADDR_STATUS`, `ADDR_CYCLES`;
  - STATUS bit positions;
  - field width of count.
- Sub-module `tx_fifo` (parameters `WIDTH`=8, `DEPTH`):
  - ports: push/pop with data, full, empty, count;
  - drops pushes when full;
  - asynchronous active-low reset.
- Top level contains address decode, the RAM array, GPIO, CYCLES, overflow flag and the read mux.

## Test plan
- RAM round trip: write 0xDEADBEEF to 0x10, then read 0x10 gives 0xDEADBEEF. Same-cycle read of 0x10 during a write of 0x12345678 gives 0xDEADBEEF; the next cycle gives 0x12345678.
- Out-of-range access: read 0x800 (with `DEPTH_WORDS`=64) and read 0x1004 both give 0. Write 0x55 to 0x100C, then CYCLES is unaffected.
- Counter: N cycles after reset release, CYCLES reads N. A counter forced near 0xFFFFFFFF wraps to 0.
- FIFO with `tx_ready`=0:
  - push 0xA1, 0xB2, 0xC3, 0xD4 → STATUS full=1, count=4;
  - push 0xE5 → overflow=1, byte dropped;
  - raise `tx_ready` → `tx_data` sequence A1, B2, C3, D4, then `tx_valid`=0;
  - write STATUS → overflow=0.
- Push while draining with `tx_ready`=1 and count=2 → count stays 2 and byte order is preserved. Push to a full FIFO during a pop → dropped, overflow=1.
- Reset mid-operation: assert `reset`=0 with FIFO count 3 and GPIO=0x0F → immediately `tx_valid`=0, `gpio_out`=0. After release, STATUS reads empty=1, count=0, and CYCLES restarts at 0.
